// File: rtl/fetch_stage_if.sv
// Instruction-memory bus and IF/ID bundle between fetch_stage and its neighbours.
// master = fetch_stage side, slave = memory / decode side.
interface fetch_stage_if #(
    parameter int WIDTH = 16,
    parameter int PC_W  = 32
);
    logic [PC_W-1:0]  imem_addr;
    logic [WIDTH-1:0] imem_data;
    logic [WIDTH-1:0] ifid_instr;
    logic [PC_W-1:0]  ifid_pc;
    logic             ifid_ldm_val;
    logic             ifid_int;

    modport master (
        output imem_addr,
        input  imem_data,
        output ifid_instr,
        output ifid_pc,
        output ifid_ldm_val,
        output ifid_int
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_ldm_val,
        input  ifid_int
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register: PC select, stalls, flushes, LDM immediate tagging.
// Define IF_INT_EN to enable interrupt-bubble injection.
module fetch_stage #(
    parameter int              WIDTH    = 16,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      LDM_OPC  = 5'h0C
) (
    input  logic             clk,
    input  logic             rst,
    fetch_stage_if.master    bus,
    input  logic             load_use,
    input  logic             freeze_cu,
    input  logic             fetch_pc_en,
    input  logic             flush,
    input  logic [1:0]       pc_sel,
    input  logic [PC_W-1:0]  pc_jmp,
    input  logic [WIDTH-1:0] pop_data,
    input  logic             pop_pc1,
    input  logic             pop_pc2,
    input  logic             int_req,
    output logic [PC_W-1:0]  pc_out
);

    logic [PC_W-1:0]  pc_q,         pc_d;
    logic [WIDTH-1:0] pc_hi_q,      pc_hi_d;
    logic             ldm_pend_q,   ldm_pend_d;
    logic [WIDTH-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]  ifid_pc_q,    ifid_pc_d;
    logic             ifid_ldm_q,   ifid_ldm_d;
    logic             ifid_int_d;

    logic             stall;
    logic             redir_stk;
    logic             redir_jmp;
    logic             redirect;
    logic             int_acc;
    logic             is_ldm;
    logic [PC_W-1:0]  pc_inc;

    logic             pc_hold;
    logic             pc_adv;
    logic             ifid_nop;
    logic             ifid_hold;
    logic             ifid_bub;
    logic             ifid_adv;

    assign stall     = load_use | freeze_cu | ~fetch_pc_en;
    assign redir_stk = (pc_sel == 2'b10) & pop_pc2;
    assign redir_jmp = (pc_sel == 2'b01);
    assign redirect  = redir_stk | redir_jmp;
    assign pc_inc    = pc_q + 1'b1;

    // The immediate word of an LDM may itself look like an LDM; never chain.
    assign is_ldm = (bus.imem_data[WIDTH-1:WIDTH-5] == LDM_OPC) & ~ldm_pend_q;

    assign pc_hold = ~redirect & (stall | int_acc);
    assign pc_adv  = ~redirect & ~stall & ~int_acc;

    assign ifid_nop  = redirect | flush;
    assign ifid_hold = ~ifid_nop & stall;
    assign ifid_bub  = int_acc;
    assign ifid_adv  = ~ifid_nop & ~stall & ~int_acc;

`ifdef IF_INT_EN
    logic int_pend_q, int_pend_d;
    logic ifid_int_q;

    assign int_acc = int_pend_q & ~stall & ~redirect
                   & ~flush & ~ldm_pend_q;
    // A request landing on the accept cycle must survive the clear.
    assign int_pend_d = int_acc ? int_req : (int_pend_q | int_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            int_pend_q <= 1'b0;
            ifid_int_q <= 1'b0;
        end else begin
            int_pend_q <= int_pend_d;
            ifid_int_q <= ifid_int_d;
        end
    end

    assign bus.ifid_int = ifid_int_q;
`else
    logic int_req_unused;
    logic ifid_int_unused;

    assign int_acc         = 1'b0;
    assign int_req_unused  = int_req;
    assign ifid_int_unused = ifid_int_d;
    assign bus.ifid_int    = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        pc_hi_d = pc_hi_q;
        if (pop_pc1) begin
            pc_hi_d = pop_data;
        end
        unique case (1'b1)
            redir_stk: pc_d = PC_W'({pc_hi_q, pop_data});
            redir_jmp: pc_d = pc_jmp;
            pc_hold:   pc_d = pc_q;
            pc_adv:    pc_d = pc_inc;
            default:   pc_d = pc_q;
        endcase
    end

    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_ldm_d   = ifid_ldm_q;
        ifid_int_d   = bus.ifid_int;
        ldm_pend_d   = ldm_pend_q;
        unique case (1'b1)
            ifid_nop: begin
                ifid_instr_d = '0;
                ifid_pc_d    = '0;
                ifid_ldm_d   = 1'b0;
                ifid_int_d   = 1'b0;
                ldm_pend_d   = 1'b0;
            end
            ifid_hold: begin
                ifid_instr_d = ifid_instr_q;
            end
            ifid_bub: begin
                ifid_instr_d = '0;
                ifid_pc_d    = pc_q;
                ifid_ldm_d   = 1'b0;
                ifid_int_d   = 1'b1;
            end
            ifid_adv: begin
                ifid_instr_d = bus.imem_data;
                ifid_pc_d    = pc_inc;
                ifid_ldm_d   = ldm_pend_q;
                ifid_int_d   = 1'b0;
                ldm_pend_d   = is_ldm;
            end
            default: begin
                ifid_instr_d = ifid_instr_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            pc_hi_q      <= '0;
            ldm_pend_q   <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            ifid_ldm_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pc_hi_q      <= pc_hi_d;
            ldm_pend_q   <= ldm_pend_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_ldm_q   <= ifid_ldm_d;
        end
    end

    assign bus.imem_addr    = pc_q;
    assign bus.ifid_instr   = ifid_instr_q;
    assign bus.ifid_pc      = ifid_pc_q;
    assign bus.ifid_ldm_val = ifid_ldm_q;
    assign pc_out           = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random traffic.
// Build with +define+IF_INT_EN on both files to exercise interrupts.
module tb_fetch_stage;
    localparam int WIDTH = 16;
    localparam int PC_W  = 32;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] instr;
        logic [31:0] ipc;
        bit          care_pc;
        bit          ldm;
        bit          intf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_use, freeze_cu, fetch_pc_en, flush;
    logic [1:0]  pc_sel;
    logic [31:0] pc_jmp;
    logic [15:0] pop_data;
    logic        pop_pc1, pop_pc2, int_req;
    logic [31:0] pc_out;

    logic [15:0] mem [256];
    exp_t        q [$];
    int          checks = 0;
    int          failures = 0;

    // reference state
    logic [31:0] m_pc, m_ipc;
    logic [15:0] m_hi, m_instr;
    bit          m_ldm, m_ip, m_care, m_ldmv, m_int;

    fetch_stage_if #(.WIDTH(WIDTH), .PC_W(PC_W)) bus ();

    fetch_stage #(.WIDTH(WIDTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .load_use    (load_use),
        .freeze_cu   (freeze_cu),
        .fetch_pc_en (fetch_pc_en),
        .flush       (flush),
        .pc_sel      (pc_sel),
        .pc_jmp      (pc_jmp),
        .pop_data    (pop_data),
        .pop_pc1     (pop_pc1),
        .pop_pc2     (pop_pc2),
        .int_req     (int_req),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr[7:0]];

    task automatic set_idle();
        rst = 0; load_use = 0; freeze_cu = 0; fetch_pc_en = 1;
        flush = 0; pc_sel = 2'b00; pc_jmp = '0; pop_data = '0;
        pop_pc1 = 0; pop_pc2 = 0; int_req = 0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        bit st, rs, rj, acc;
        logic [31:0] npc;
        if (rst) begin
            m_pc = 0; m_hi = 0; m_ldm = 0; m_ip = 0;
            m_instr = 0; m_ipc = 0; m_care = 1; m_ldmv = 0; m_int = 0;
            return;
        end
        w   = mem[m_pc[7:0]];
        st  = load_use || freeze_cu || !fetch_pc_en;
        rs  = (pc_sel == 2) && pop_pc2;
        rj  = (pc_sel == 1);
        acc = 0;
`ifdef IF_INT_EN
        acc = m_ip && !st && !rs && !rj && !flush && !m_ldm;
`endif
        if (rs)             npc = {m_hi, pop_data};
        else if (rj)        npc = pc_jmp;
        else if (st || acc) npc = m_pc;
        else                npc = m_pc + 1;
        if (rs || rj || flush) begin
            m_instr = 0; m_ldmv = 0; m_int = 0; m_care = 0; m_ldm = 0;
        end else if (st) begin
            // IF/ID and LDM tracking hold
        end else if (acc) begin
            m_instr = 0; m_ipc = m_pc; m_care = 1; m_ldmv = 0; m_int = 1;
        end else begin
            m_instr = w; m_ipc = m_pc + 1; m_care = 1;
            m_ldmv = m_ldm; m_int = 0;
            m_ldm = (w[15:11] == 5'h0C) && !m_ldm;
        end
`ifdef IF_INT_EN
        m_ip = acc ? int_req : (m_ip || int_req);
`endif
        if (pop_pc1) m_hi = pop_data;
        m_pc = npc;
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc;
        e.care_pc = m_care; e.ldm = m_ldmv; e.intf = m_int;
        q.push_back(e);
        @(negedge clk);
        set_idle();
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("imem_addr", bus.imem_addr, e.pc);
                chk("ifid_instr", {16'h0, bus.ifid_instr}, {16'h0, e.instr});
                if (e.care_pc) chk("ifid_pc", bus.ifid_pc, e.ipc);
                chk("ifid_ldm_val", {31'h0, bus.ifid_ldm_val}, {31'h0, e.ldm});
                chk("ifid_int", {31'h0, bus.ifid_int}, {31'h0, e.intf});
            end
        end
    end

    initial begin : driver
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 5) == 0) w[15:11] = 5'h0C;
            mem[i] = w;
        end
        for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);
        mem[0] = 16'h1234; mem[1] = 16'h5678;
        mem[3] = 16'h6001; mem[4] = 16'h6000;
        mem[8] = 16'h6123; mem[9] = 16'h0ABC;

        set_idle();
        rst = 1;
        @(negedge clk);
        rst = 1; cycle();
        repeat (5) cycle();
        load_use = 1; cycle();
        load_use = 1; cycle();
        repeat (2) cycle();
        pc_sel = 2'b01; pc_jmp = 32'h40; load_use = 1; cycle();
        cycle();
        pop_pc1 = 1; pop_data = 16'h0001; cycle();
        pc_sel = 2'b10; pop_pc2 = 1; pop_data = 16'h0020; cycle();
        repeat (2) cycle();
        pc_sel = 2'b01; pc_jmp = 32'h3; cycle();
        flush = 1; cycle();
        repeat (3) cycle();
        pc_sel = 2'b01; pc_jmp = 32'hFFFF_FFFF; cycle();
        repeat (3) cycle();
        freeze_cu = 1; cycle();
        fetch_pc_en = 0; cycle();
        pc_sel = 2'b11; cycle();
`ifdef IF_INT_EN
        pc_sel = 2'b01; pc_jmp = 32'h8; cycle();
        cycle();
        int_req = 1; cycle();
        repeat (3) cycle();
        int_req = 1; load_use = 1; cycle();
        rst = 1; cycle();
        repeat (3) cycle();
`endif
        for (int n = 0; n < 3000; n++) begin
            load_use    = ($urandom_range(0, 99) < 12);
            freeze_cu   = ($urandom_range(0, 99) < 4);
            fetch_pc_en = ($urandom_range(0, 99) >= 4);
            flush       = ($urandom_range(0, 99) < 7);
            case ($urandom_range(0, 19))
                0, 1:    pc_sel = 2'b01;
                2, 3:    pc_sel = 2'b10;
                4:       pc_sel = 2'b11;
                default: pc_sel = 2'b00;
            endcase
            pc_jmp   = $urandom_range(0, 1) ? 32'($urandom_range(0, 255))
                                            : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            pop_data = 16'($urandom);
            pop_pc1  = ($urandom_range(0, 99) < 6);
            pop_pc2  = !pop_pc1 && ($urandom_range(0, 99) < 50);
            int_req  = ($urandom_range(0, 99) < 5);
            rst      = ($urandom_range(0, 99) < 1);
            cycle();
        end
        repeat (3) cycle();
        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
